mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one word-wide memory port between the instruction-fetch requester (read-only) and the
//  load/store requester (read/write, byte enables). Sits between the pipeline IF/MEM stages and
//  the unified memory. Serialises accesses, gives data priority with starvation guard, returns
//  read data with one-cycle ack pulses. Supports combinational or 1-cycle synchronous memories.
// PARAMETERS
//  READ_LATENCY  0   memory rdata valid: 0 = same cycle as mem_ce, 1 = cycle after mem_ce
//  MAX_DATA_RUN  4   consecutive data grants allowed while inst_req pending (1..15)
//  AW            32  byte address width
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  inst_req    in   1   fetch request; held with inst_addr stable until inst_ack
//  inst_addr   in   AW  fetch byte address
//  inst_rdata  out  32  fetched word; valid with inst_ack, held until next inst_ack
//  inst_ack    out  1   one-cycle completion pulse
//  inst_err    out  1   with inst_ack: misaligned address, no memory access made
//  data_req    in   1   load/store request; held with addr/we/be/wdata stable until data_ack
//  data_we     in   1   1 = store, 0 = load
//  data_be     in   4   byte enables for store; ignored for load
//  data_addr   in   AW  byte address
//  data_wdata  in   32  store data
//  data_rdata  out  32  load word; valid with data_ack, held until next data_ack
//  data_ack    out  1   one-cycle completion pulse (loads and stores)
//  data_err    out  1   with data_ack: misaligned address or store with data_be==0; no access
//  mem_ce      out  1   memory chip enable
//  mem_we      out  4   per-byte write strobes (0 for reads)
//  mem_addr    out  AW  memory byte address
//  mem_wdata   out  32  memory write data
//  mem_rdata   in   32  memory read data
//  busy        out  1   high in every state except IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0, rdata regs 0, starve count 0.
//  - FSM IDLE -> ACCESS -> [WAIT if READ_LATENCY=1] -> RESP -> IDLE.
//  - IDLE: sample reqs; winner's addr/we/be/wdata latched; owner latched; go ACCESS.
//    No request: stay IDLE.
//  - Arbitration: data only -> data; inst only -> inst; both -> data unless
//    starve_cnt == MAX_DATA_RUN, then inst.
//  - starve_cnt: +1 on each data grant while inst_req high, saturating at MAX_DATA_RUN.
//    Clears on inst grant or when inst_req low in IDLE.
//  - ACCESS: mem_ce=1 for exactly one cycle; mem_we=be if store, else 0.
//    LAT=0: capture mem_rdata at end of ACCESS. LAT=1: go WAIT (mem_ce=0), capture at end of WAIT.
//  - Error check in IDLE (addr[1:0]!=0, or store with be==0): skip ACCESS/WAIT, go straight to
//    RESP with err=1. rdata regs unchanged; mem_ce stays 0.
//  - RESP: ack=1 for owner only, one cycle; err valid same cycle; go IDLE.
//  - Latency, req high in IDLE at cycle 0 -> ack at cycle 2 (LAT=0), 3 (LAT=1), 1 (error).
//  - Back-to-back: req still high in IDLE after ack is a new request.
//    Throughput is one access per 3 (LAT=0) or 4 (LAT=1) cycles.
//  - Requester dropping req before ack is illegal; the latched transaction still completes.
//  - rst_n low mid-operation: mem_ce/mem_we clear immediately (async); in-flight access is
//    dropped, no ack, no partial write after reset edge.
//  - mem_addr/mem_wdata hold last value when mem_ce=0.
// STRUCTURE
//  - mem_arb_pkg: state enum (IDLE, ACCESS, WAIT, RESP), owner constants (OWN_INST, OWN_DATA),
//    word-align check function.
//  - One sub-module: arb_starve_cnt (saturating counter, inc/clr/at_max); FSM and datapath
//    regs stay in top.
// TESTING
//  1. LAT=0, inst_req addr 0x8 only -> mem_ce at cycle 1, addr 0x8; inst_ack cycle 2,
//     inst_rdata = mem word 2.
//  2. Store addr 0x10, be=4'b0011, wdata 0xDEADBEEF -> mem_we=0011 one cycle; data_ack, err=0;
//     load 0x10 returns 0x0000BEEF over zeroed memory.
//  3. inst_req and data_req held high continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,I
//     repeating; no inst starvation.
//  4. data_addr 0x6 load -> data_ack+data_err at cycle 1, mem_ce never asserted,
//     data_rdata unchanged.
//  5. LAT=1, load 0x20 -> mem_ce cycle 1 only, rdata captured cycle 2, data_ack cycle 3.
//  6. rst_n pulsed low during ACCESS of a store -> mem_we drops at once; no ack;
//     busy=0; location unmodified.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
// Holds the FSM state encoding, requester identities and the alignment check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Wide enough for the largest allowed data run (15).
  localparam int unsigned STARVE_W = 4;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while a fetch is waiting.
// Clear has priority over increment.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_VAL = STARVE_W'(MAX_RUN);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto a single word-wide memory port.
// Data wins contention unless a fetch has waited MAX_DATA_RUN data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [31:0]   inst_rdata,
  output logic          inst_ack,
  output logic          inst_err,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [3:0]    data_be,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic [31:0]   data_rdata,
  output logic          data_ack,
  output logic          data_err,
  output logic          mem_ce,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          store_q, store_d;
  logic          mem_ce_q, mem_ce_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          inst_ack_q, inst_ack_d;
  logic          inst_err_q, inst_err_d;
  logic          data_ack_q, data_ack_d;
  logic          data_err_q, data_err_d;
  logic          busy_q, busy_d;

  logic grant_inst, grant_data, req_err, capture;
  logic cnt_inc, cnt_clr, starve_at_max;

  arb_starve_cnt #(
    .MAX_RUN (MAX_DATA_RUN)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (starve_at_max)
  );

  // NOTE: every variable gets a default before the case so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    store_d      = store_q;
    mem_ce_d     = 1'b0;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    req_err      = 1'b0;
    capture      = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        grant_data = data_req && !(inst_req && starve_at_max);
        grant_inst = inst_req && !grant_data;
        cnt_inc    = grant_data && inst_req;
        cnt_clr    = grant_inst || !inst_req;
        if (grant_data) begin
          owner_d = OWN_DATA;
          store_d = data_we;
          req_err = !is_word_aligned(data_addr[1:0]) || (data_we && (data_be == 4'b0000));
        end else if (grant_inst) begin
          owner_d = OWN_INST;
          store_d = 1'b0;
          req_err = !is_word_aligned(inst_addr[1:0]);
        end
        // Faulty requests bypass the memory entirely and answer next cycle.
        if (req_err) begin
          state_d = ST_RESP;
        end else if (grant_data || grant_inst) begin
          state_d    = ST_ACCESS;
          mem_ce_d   = 1'b1;
          mem_addr_d = grant_data ? data_addr : inst_addr;
          if (grant_data && data_we) begin
            mem_we_d    = data_be;
            mem_wdata_d = data_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (READ_LATENCY == 0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (owner_q == OWN_INST) begin
        inst_rdata_d = mem_rdata;
      end else if (!store_q) begin
        data_rdata_d = mem_rdata;
      end
    end

    inst_ack_d = (state_d == ST_RESP) && (owner_d == OWN_INST);
    data_ack_d = (state_d == ST_RESP) && (owner_d == OWN_DATA);
    inst_err_d = req_err && (owner_d == OWN_INST);
    data_err_d = req_err && (owner_d == OWN_DATA);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      store_q      <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ack_q   <= 1'b0;
      inst_err_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ack_q   <= inst_ack_d;
      inst_err_q   <= inst_err_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      busy_q       <= busy_d;
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign inst_ack   = inst_ack_q;
  assign inst_err   = inst_err_q;
  assign data_rdata = data_rdata_q;
  assign data_ack   = data_ack_q;
  assign data_err   = data_err_q;
  assign mem_ce     = mem_ce_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per read latency, each with its own memory,
// checked against a transaction-level model of memory contents, latency and grant order.
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int MAX_RUN = 4;

  logic          clk;
  logic          rst_n;
  logic          init_mem;
  logic          inst_req   [2];
  logic [AW-1:0] inst_addr  [2];
  logic [31:0]   inst_rdata [2];
  logic          inst_ack   [2];
  logic          inst_err   [2];
  logic          data_req   [2];
  logic          data_we    [2];
  logic [3:0]    data_be    [2];
  logic [AW-1:0] data_addr  [2];
  logic [31:0]   data_wdata [2];
  logic [31:0]   data_rdata [2];
  logic          data_ack   [2];
  logic          data_err   [2];
  logic          mem_ce     [2];
  logic [3:0]    mem_we     [2];
  logic [AW-1:0] mem_addr   [2];
  logic [31:0]   mem_wdata  [2];
  logic [31:0]   mem_rdata  [2];
  logic          busy       [2];

  logic [31:0] mem     [2][256];
  logic [31:0] rd_q    [2];
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rd [2][2];   // [dut][0 = inst, 1 = data]

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .READ_LATENCY (g),
      .MAX_DATA_RUN (MAX_RUN),
      .AW           (AW)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_req   (inst_req[g]),
      .inst_addr  (inst_addr[g]),
      .inst_rdata (inst_rdata[g]),
      .inst_ack   (inst_ack[g]),
      .inst_err   (inst_err[g]),
      .data_req   (data_req[g]),
      .data_we    (data_we[g]),
      .data_be    (data_be[g]),
      .data_addr  (data_addr[g]),
      .data_wdata (data_wdata[g]),
      .data_rdata (data_rdata[g]),
      .data_ack   (data_ack[g]),
      .data_err   (data_err[g]),
      .mem_ce     (mem_ce[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );
  end

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 4) ? 32'h0 : {8'hA0, b, ~b, 8'(i * 3)};
  endfunction

  // Instance 0 sees a combinational memory, instance 1 a registered one.
  assign mem_rdata[0] = mem[0][mem_addr[0][9:2]];
  assign mem_rdata[1] = rd_q[1];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (init_mem) begin
        for (int i = 0; i < 256; i++) mem[d][i] <= init_word(i);
      end else if (mem_ce[d]) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[d][b]) mem[d][mem_addr[d][9:2]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
        rd_q[d] <= mem[d][mem_addr[d][9:2]];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model_rdata();
    for (int d = 0; d < 2; d++) begin
      last_rd[d][0] = '0;
      last_rd[d][1] = '0;
    end
  endtask

  // One request on one port of DUT d; inputs driven at negedge, outputs sampled at negedge.
  task automatic run_txn(input int d, input bit is_data, input bit we, input logic [3:0] be,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
    bit          err;
    bit          got;
    int          lat;
    int          cyc;
    int          ce_cnt;
    logic [3:0]  we_seen;
    logic [31:0] addr_seen;
    logic [7:0]  idx;
    err       = (addr[1:0] != 2'b00) || (is_data && we && be == 4'b0000);
    lat       = err ? 1 : 2 + d;
    got       = 1'b0;
    cyc       = 0;
    ce_cnt    = 0;
    we_seen   = '0;
    addr_seen = '0;
    idx       = addr[9:2];
    if (is_data) begin
      data_req[d] = 1'b1; data_we[d] = we; data_be[d] = be;
      data_addr[d] = addr; data_wdata[d] = wdata;
    end else begin
      inst_req[d] = 1'b1; inst_addr[d] = addr;
    end
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_ce[d]) begin
        ce_cnt++;
        we_seen   = mem_we[d];
        addr_seen = mem_addr[d];
      end
      if (inst_ack[d] || data_ack[d]) got = 1'b1;
    end
    check("ack_latency", got ? cyc : -1, lat);
    check("ack_port", 32'({inst_ack[d], data_ack[d]}), is_data ? 32'd1 : 32'd2);
    check("err_flag", 32'(is_data ? data_err[d] : inst_err[d]), 32'(err));
    check("mem_ce_count", ce_cnt, err ? 0 : 1);
    if (!err) begin
      check("mem_addr", addr_seen, addr);
      check("mem_we", 32'(we_seen), (is_data && we) ? 32'(be) : 32'd0);
      if (is_data && we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        last_rd[d][is_data] = ref_mem[d][idx];
      end
    end
    if (is_data) check("data_rdata", data_rdata[d], last_rd[d][1]);
    else         check("inst_rdata", inst_rdata[d], last_rd[d][0]);
    inst_req[d] = 1'b0;
    data_req[d] = 1'b0;
    @(negedge clk);
    check("busy_after", 32'(busy[d]), 32'd0);
  endtask

  // Both requesters held high: data wins until MAX_RUN data grants have gone by, then fetch.
  task automatic contention(input int d, input int n);
    int run;
    int cyc;
    bit got;
    run = 0;
    inst_req[d] = 1'b1; inst_addr[d] = 32'h40;
    data_req[d] = 1'b1; data_we[d] = 1'b0; data_be[d] = 4'h0; data_addr[d] = 32'h44;
    for (int k = 0; k < n; k++) begin
      bit exp_inst;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (inst_ack[d] || data_ack[d]) got = 1'b1;
      end
      exp_inst = (run == MAX_RUN);
      run      = exp_inst ? 0 : run + 1;
      check("grant_order", 32'({inst_ack[d], data_ack[d]}), exp_inst ? 32'd2 : 32'd1);
      check("grant_gap", got ? cyc : -1, (k == 0) ? 2 + d : 3 + d);
      if (exp_inst) check("cont_inst_rdata", inst_rdata[d], ref_mem[d][16]);
      else          check("cont_data_rdata", data_rdata[d], ref_mem[d][17]);
    end
    inst_req[d] = 1'b0;
    data_req[d] = 1'b0;
    repeat (2) @(negedge clk);
    last_rd[d][0] = ref_mem[d][16];
    last_rd[d][1] = ref_mem[d][17];
  endtask

  initial begin
    rst_n    = 1'b0;
    init_mem = 1'b1;
    for (int d = 0; d < 2; d++) begin
      inst_req[d] = 1'b0; inst_addr[d] = '0;
      data_req[d] = 1'b0; data_we[d] = 1'b0; data_be[d] = '0;
      data_addr[d] = '0; data_wdata[d] = '0;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
    end
    clear_model_rdata();
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check("rst_ctrl", 32'({busy[d], inst_ack[d], inst_err[d], data_ack[d], data_err[d],
                              mem_ce[d], mem_we[d]}), 32'd0);
      check("rst_mem_addr", mem_addr[d], 32'd0);
      check("rst_mem_wdata", mem_wdata[d], 32'd0);
      check("rst_inst_rdata", inst_rdata[d], 32'd0);
      check("rst_data_rdata", data_rdata[d], 32'd0);
    end

    for (int d = 0; d < 2; d++) begin
      run_txn(d, 1'b0, 1'b0, 4'h0, 32'h8, 32'h0);
      check("fetch_word2", inst_rdata[d], 32'hA002FD06);
      run_txn(d, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEADBEEF);
      run_txn(d, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      check("partial_store", data_rdata[d], 32'h0000BEEF);
      run_txn(d, 1'b1, 1'b0, 4'h0, 32'h6, 32'h0);
      check("err_rdata_kept", data_rdata[d], 32'h0000BEEF);
      run_txn(d, 1'b1, 1'b1, 4'h0, 32'h14, 32'h12345678);
      run_txn(d, 1'b0, 1'b0, 4'h0, 32'h23, 32'h0);
      run_txn(d, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      contention(d, 11);
    end

    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 40; t++) begin
        logic [AW-1:0] addr;
        addr = AW'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        run_txn(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), addr, $urandom);
      end
    end

    // Reset during the ACCESS cycle of a store on the zero-latency instance.
    data_req[0] = 1'b1; data_we[0] = 1'b1; data_be[0] = 4'hF;
    data_addr[0] = 32'h24; data_wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    check("pre_rst_ce", 32'({mem_ce[0], mem_we[0]}), 32'h1F);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_ce", 32'(mem_ce[0]), 32'd0);
    check("rst_async_we", 32'(mem_we[0]), 32'd0);
    data_req[0] = 1'b0;
    clear_model_rdata();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int acks;
      acks = 0;
      repeat (4) begin
        @(negedge clk);
        if (inst_ack[0] || data_ack[0] || inst_ack[1] || data_ack[1]) acks++;
      end
      check("rst_no_ack", acks, 0);
    end
    check("rst_busy", 32'({busy[0], busy[1]}), 32'd0);
    check("rst_no_write", mem[0][9], ref_mem[0][9]);
    run_txn(0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);

    for (int d = 0; d < 2; d++) begin
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem[d][i] !== ref_mem[d][i]) bad++;
      check("mem_image", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
